uart_tx_ctrl: RTL and testbench

- Frame sequencer for the UART transmit path.
- Accepts one byte at a time over a valid/ready handshake and latches the frame configuration.
- Uses the existing `parity` block to compute the parity bit.
- Serialises start, data (LSB first), optional parity and stop bits onto `tx_o`, paced by the oversampling tick from the baud generator.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_ctrl_parity.sv | 26 ++
 rtl/uart_tx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam logic [1:0] DBN_5 = 2'b00;
   localparam logic [1:0] DBN_6 = 2'b01;
   localparam logic [1:0] DBN_7 = 2'b10;
   localparam logic [1:0] DBN_8 = 2'b11;

   localparam int OVS_DEFAULT = 16;

   // Index of the final data bit for a given length code (4..7).
   function automatic logic [2:0] last_data_idx(input logic [1:0] dbn);
      return 3'd4 + {1'b0, dbn};
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_parity.sv
// Parity bit generator over the configured number of data bits.
module parity
   import uart_pkg::*;
(
   input  logic [7:0] data_i,
   input  logic [1:0] data_bit_num_i,
   input  logic       parity_type_i,
   output logic       parity_o
);

   logic [7:0] mask;

   always_comb begin
      mask = 8'hFF;
      unique case (data_bit_num_i)
         DBN_5:   mask = 8'h1F;
         DBN_6:   mask = 8'h3F;
         DBN_7:   mask = 8'h7F;
         default: mask = 8'hFF;
      endcase
   end

   // High when the masked word already carries the selected parity (0 even, 1 odd).
   assign parity_o = ~((^(data_i & mask)) ^ parity_type_i);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int OVS = OVS_DEFAULT
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tick_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   input  logic [7:0] tx_data_i,
   input  logic [1:0] data_bit_num_i,
   input  logic       parity_en_i,
   input  logic       parity_type_i,
   input  logic       stop_bit_num_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       tx_done_o
);

   localparam int TW = $clog2(OVS);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);

   tx_state_e     state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [1:0]    dbn_q, dbn_d;
   logic          par_en_q, par_en_d;
   logic          par_bit_q, par_bit_d;
   logic          stop2_q, stop2_d;
   logic          tx_q, tx_d;
   logic          done_q, done_d;
   logic          par_live;
   logic          bit_end;

   parity u_parity (
      .data_i         (tx_data_i),
      .data_bit_num_i (data_bit_num_i),
      .parity_type_i  (parity_type_i),
      .parity_o       (par_live)
   );

   assign bit_end = tick_i && (tick_cnt_q == TICK_LAST);

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      dbn_d      = dbn_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      stop2_d    = stop2_q;
      tx_d       = tx_q;
      done_d     = 1'b0;

      if (state_q != IDLE && tick_i) begin
         tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (tx_valid_i) begin
               shreg_d    = tx_data_i;
               dbn_d      = data_bit_num_i;
               par_en_d   = parity_en_i;
               par_bit_d  = par_live;
               stop2_d    = stop_bit_num_i;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               tx_d       = 1'b0;
               state_d    = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_d      = shreg_q[0];
               shreg_d   = {1'b0, shreg_q[7:1]};
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == last_data_idx(dbn_q)) begin
                  bit_cnt_d = '0;
                  if (par_en_q) begin
                     tx_d    = par_bit_q;
                     state_d = PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = STOP;
                  end
               end else begin
                  tx_d      = shreg_q[0];
                  shreg_d   = {1'b0, shreg_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               tx_d      = 1'b1;
               bit_cnt_d = '0;
               state_d   = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               tx_d = 1'b1;
               // bit_cnt counts completed stop bits here.
               if (bit_cnt_q[0] == stop2_q) begin
                  bit_cnt_d = '0;
                  done_d    = 1'b1;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         dbn_q      <= DBN_5;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         stop2_q    <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         dbn_q      <= dbn_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         stop2_q    <= stop2_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   assign tx_ready_o = (state_q == IDLE);
   assign busy_o     = (state_q != IDLE);
   assign tx_o       = tx_q;
   assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed table-driven bench for uart_tx_ctrl, plus a mid-frame reset sequence.
module tb_uart_tx_ctrl;

   localparam int OVS = 16;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       tick_i;
   logic       tx_valid_i;
   logic       tx_ready_o;
   logic [7:0] tx_data_i;
   logic [1:0] data_bit_num_i;
   logic       parity_en_i;
   logic       parity_type_i;
   logic       stop_bit_num_i;
   logic       tx_o;
   logic       busy_o;
   logic       tx_done_o;

   int checks   = 0;
   int failures = 0;

   uart_tx_ctrl #(.OVS(OVS)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .tick_i         (tick_i),
      .tx_valid_i     (tx_valid_i),
      .tx_ready_o     (tx_ready_o),
      .tx_data_i      (tx_data_i),
      .data_bit_num_i (data_bit_num_i),
      .parity_en_i    (parity_en_i),
      .parity_type_i  (parity_type_i),
      .stop_bit_num_i (stop_bit_num_i),
      .tx_o           (tx_o),
      .busy_o         (busy_o),
      .tx_done_o      (tx_done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  data;
      logic [1:0]  dbn;
      logic        pen;
      logic        ptype;
      logic        stop2;
      int          div;
      logic        hold;
      logic [11:0] exp_bits;
      int          nbits;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Entered #1 after an edge with the DUT idle; leaves #1 after the done edge.
   task automatic run_frame(input int idx);
      vec_t v;
      int   len;
      int   bit_err;
      int   hs_err;
      int   done_err;
      v = vecs[idx];
      len = v.nbits * OVS * v.div;
      bit_err = 0;
      hs_err = 0;
      done_err = 0;
      tx_data_i      = v.data;
      data_bit_num_i = v.dbn;
      parity_en_i    = v.pen;
      parity_type_i  = v.ptype;
      stop_bit_num_i = v.stop2;
      tx_valid_i     = 1'b1;
      tick_i         = 1'b0;
      @(posedge clk); #1;
      check($sformatf("f%0d_accept_tx", idx), 32'(tx_o), 32'd0);
      check($sformatf("f%0d_accept_busy", idx), 32'(busy_o), 32'd1);
      check($sformatf("f%0d_accept_ready", idx), 32'(tx_ready_o), 32'd0);
      for (int c = 1; c <= len; c++) begin
         tick_i = ((c % v.div) == 0);
         if (!v.hold) tx_valid_i = 1'b0;
         if (c == 20) begin
            tx_data_i      = ~v.data;
            data_bit_num_i = ~v.dbn;
            parity_en_i    = ~v.pen;
            parity_type_i  = ~v.ptype;
            stop_bit_num_i = ~v.stop2;
         end
         @(posedge clk); #1;
         if (c < len) begin
            if (tx_o !== v.exp_bits[c / (OVS * v.div)]) bit_err++;
            if (busy_o !== 1'b1 || tx_ready_o !== 1'b0) hs_err++;
            if (tx_done_o !== 1'b0) done_err++;
         end else begin
            check($sformatf("f%0d_done_pulse", idx), 32'(tx_done_o), 32'd1);
            check($sformatf("f%0d_end_tx", idx), 32'(tx_o), 32'd1);
            check($sformatf("f%0d_end_ready", idx), 32'(tx_ready_o), 32'd1);
            check($sformatf("f%0d_end_busy", idx), 32'(busy_o), 32'd0);
         end
      end
      tick_i = 1'b0;
      check($sformatf("f%0d_bit_errors", idx), 32'(bit_err), 32'd0);
      check($sformatf("f%0d_busy_errors", idx), 32'(hs_err), 32'd0);
      check($sformatf("f%0d_early_done", idx), 32'(done_err), 32'd0);
   endtask

   initial begin
      // data, dbn, pen, ptype, stop2, tick divider, hold valid, bits (LSB first on the line), bit count
      vecs[0] = '{8'hA5, 2'b11, 1'b1, 1'b0, 1'b0, 1, 1'b0, 12'h74A, 11};
      vecs[1] = '{8'hFF, 2'b00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 12'h0FE, 8};
      vecs[2] = '{8'hA5, 2'b11, 1'b1, 1'b1, 1'b0, 1, 1'b0, 12'h54A, 11};
      vecs[3] = '{8'h3C, 2'b10, 1'b1, 1'b0, 1'b0, 3, 1'b1, 12'h378, 10};
      vecs[4] = '{8'hEB, 2'b01, 1'b1, 1'b1, 1'b1, 1, 1'b1, 12'h356, 10};

      rst_i          = 1'b1;
      tick_i         = 1'b1;
      tx_valid_i     = 1'b1;
      tx_data_i      = 8'h00;
      data_bit_num_i = 2'b11;
      parity_en_i    = 1'b0;
      parity_type_i  = 1'b0;
      stop_bit_num_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", 32'(tx_o), 32'd1);
      check("rst_ready", 32'(tx_ready_o), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(tx_done_o), 32'd0);
      rst_i      = 1'b0;
      tick_i     = 1'b0;
      tx_valid_i = 1'b0;
      @(posedge clk); #1;
      check("idle_tx", 32'(tx_o), 32'd1);

      for (int i = 0; i < 5; i++) run_frame(i);

      // Abort a frame during data bit 3, then send a clean frame.
      tx_valid_i = 1'b0;
      @(posedge clk); #1;
      tx_data_i      = 8'hA5;
      data_bit_num_i = 2'b11;
      parity_en_i    = 1'b1;
      parity_type_i  = 1'b0;
      stop_bit_num_i = 1'b0;
      tx_valid_i     = 1'b1;
      @(posedge clk); #1;
      tx_valid_i = 1'b0;
      for (int c = 1; c < 70; c++) begin
         tick_i = 1'b1;
         @(posedge clk); #1;
      end
      check("rst_pre_bit3", 32'(tx_o), 32'd0);
      rst_i      = 1'b1;
      tx_valid_i = 1'b1;
      @(posedge clk); #1;
      check("midrst_tx", 32'(tx_o), 32'd1);
      check("midrst_ready", 32'(tx_ready_o), 32'd1);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_done", 32'(tx_done_o), 32'd0);
      rst_i      = 1'b0;
      tx_valid_i = 1'b0;
      tick_i     = 1'b0;
      begin
         int stray;
         stray = 0;
         for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (tx_done_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) stray++;
         end
         check("postrst_idle", 32'(stray), 32'd0);
      end
      run_frame(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
